i2c_bus_arbiter: RTL and testbench



---
 rtl/i2c_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one camera-side I2C transaction engine between
// three configuration requesters, with a per-transaction watchdog and a bus-free gap.
`timescale 1ns/1ps
module i2c_bus_arbiter #(
    parameter int TIMEOUT    = 200000,
    parameter int GAP_CYCLES = 65
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic [2:0]  REQ,
    input  logic [5:0]  REQ_OP,
    input  logic [23:0] REQ_SLAVE,
    input  logic [47:0] REQ_PTR,
    input  logic [47:0] REQ_WDATA,
    output logic [2:0]  GNT,
    output logic [2:0]  DONE,
    output logic [15:0] RDATA,
    output logic [1:0]  ERR_CODE,
    output logic        BUSY,
    output logic [1:0]  ENG_OP,
    output logic [7:0]  ENG_SLAVE,
    output logic [15:0] ENG_PTR,
    output logic [15:0] ENG_WDATA,
    output logic        ENG_START,
    output logic        ENG_ABORT,
    input  logic        ENG_DONE,
    input  logic        ENG_NACK,
    input  logic [15:0] ENG_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT     = 3'd2,
        S_COMPLETE = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);
    localparam logic [8:0]  GAP_LEN  = 9'(GAP_CYCLES);

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d, cur_q, cur_d;
    logic [2:0]  gnt_q, gnt_d, done_q, done_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        busy_q, busy_d, start_q, start_d, abort_q, abort_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  slave_q, slave_d;
    logic [15:0] ptr_q, ptr_d, wdata_q, wdata_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  gap_q, gap_d;

    logic [1:0]  cand1_s, cand2_s, win_s;
    logic [3:0]  req_ext_s;
    logic [1:0]  sel_op_s;
    logic [7:0]  sel_slave_s;
    logic [15:0] sel_ptr_s, sel_wdata_s;

    // Round-robin winner: search upward from the last served requester.
    always_comb begin
        cand1_s   = rr_next(last_q);
        cand2_s   = rr_next(cand1_s);
        req_ext_s = {1'b0, REQ};
        if (req_ext_s[cand1_s]) begin
            win_s = cand1_s;
        end else if (req_ext_s[cand2_s]) begin
            win_s = cand2_s;
        end else begin
            win_s = last_q;
        end
    end

    // Request field mux for the current winner.
    always_comb begin
        case (win_s)
            2'd0: begin
                sel_op_s    = REQ_OP[1:0];
                sel_slave_s = REQ_SLAVE[7:0];
                sel_ptr_s   = REQ_PTR[15:0];
                sel_wdata_s = REQ_WDATA[15:0];
            end
            2'd1: begin
                sel_op_s    = REQ_OP[3:2];
                sel_slave_s = REQ_SLAVE[15:8];
                sel_ptr_s   = REQ_PTR[31:16];
                sel_wdata_s = REQ_WDATA[31:16];
            end
            default: begin
                sel_op_s    = REQ_OP[5:4];
                sel_slave_s = REQ_SLAVE[23:16];
                sel_ptr_s   = REQ_PTR[47:32];
                sel_wdata_s = REQ_WDATA[47:32];
            end
        endcase
    end

    // Transaction FSM: next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        gnt_d   = gnt_q;
        done_d  = 3'b000;
        rdata_d = 16'h0000;
        err_d   = 2'b00;
        start_d = 1'b0;
        abort_d = 1'b0;
        op_d    = op_q;
        slave_d = slave_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (REQ != 3'b000) begin
                    cur_d   = win_s;
                    gnt_d   = onehot(win_s);
                    op_d    = (sel_op_s == 2'b11) ? 2'b00 : sel_op_s;
                    slave_d = sel_slave_s;
                    ptr_d   = sel_ptr_s;
                    wdata_d = sel_wdata_s;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                start_d = 1'b1;
                timer_d = 24'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 24'd1;
                // A completion in the watchdog's last cycle still counts as a completion.
                if (ENG_DONE) begin
                    rdata_d = ENG_RDATA;
                    err_d   = ENG_NACK ? 2'b01 : 2'b00;
                    done_d  = gnt_q;
                    state_d = S_COMPLETE;
                end else if (timer_q == TMO_LAST) begin
                    abort_d = 1'b1;
                    err_d   = 2'b10;
                    done_d  = gnt_q;
                    state_d = S_COMPLETE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_COMPLETE: begin
                gnt_d   = 3'b000;
                last_d  = cur_q;
                gap_d   = 8'd0;
                state_d = S_GAP;
            end
            S_GAP: begin
                // Always spend at least one cycle here, even with a zero gap.
                if (({1'b0, gap_q} + 9'd1) >= GAP_LEN) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d   = gap_q + 8'd1;
                    state_d = S_GAP;
                end
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            last_q  <= 2'd2;
            cur_q   <= 2'd0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            rdata_q <= 16'h0000;
            err_q   <= 2'b00;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            op_q    <= 2'b00;
            slave_q <= 8'h00;
            ptr_q   <= 16'h0000;
            wdata_q <= 16'h0000;
            timer_q <= 24'd0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            abort_q <= abort_d;
            op_q    <= op_d;
            slave_q <= slave_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
        end
    end

    assign GNT       = gnt_q;
    assign DONE      = done_q;
    assign RDATA     = rdata_q;
    assign ERR_CODE  = err_q;
    assign BUSY      = busy_q;
    assign ENG_OP    = op_q;
    assign ENG_SLAVE = slave_q;
    assign ENG_PTR   = ptr_q;
    assign ENG_WDATA = wdata_q;
    assign ENG_START = start_q;
    assign ENG_ABORT = abort_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: an edge-numbered transaction model predicts
// every output each cycle, and directed scenarios pin the model with literal values.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;
    localparam int TMO = 100;
    localparam int GAP = 3;

    logic        CLK_50    = 1'b0;
    logic        RESET_N   = 1'b0;
    logic [2:0]  REQ       = 3'b000;
    logic [5:0]  REQ_OP    = 6'b000000;
    logic [23:0] REQ_SLAVE = 24'h0;
    logic [47:0] REQ_PTR   = 48'h0;
    logic [47:0] REQ_WDATA = 48'h0;
    logic        ENG_DONE  = 1'b0;
    logic        ENG_NACK  = 1'b0;
    logic [15:0] ENG_RDATA = 16'h0;
    logic [2:0]  GNT, DONE;
    logic [15:0] RDATA, ENG_PTR, ENG_WDATA;
    logic [1:0]  ERR_CODE, ENG_OP;
    logic [7:0]  ENG_SLAVE;
    logic        BUSY, ENG_START, ENG_ABORT;

    i2c_bus_arbiter #(.TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .CLK_50(CLK_50), .RESET_N(RESET_N), .REQ(REQ), .REQ_OP(REQ_OP),
        .REQ_SLAVE(REQ_SLAVE), .REQ_PTR(REQ_PTR), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR_CODE(ERR_CODE), .BUSY(BUSY),
        .ENG_OP(ENG_OP), .ENG_SLAVE(ENG_SLAVE), .ENG_PTR(ENG_PTR), .ENG_WDATA(ENG_WDATA),
        .ENG_START(ENG_START), .ENG_ABORT(ENG_ABORT), .ENG_DONE(ENG_DONE),
        .ENG_NACK(ENG_NACK), .ENG_RDATA(ENG_RDATA)
    );

    always #10 CLK_50 = ~CLK_50;

    int n_checks = 0;
    int n_fail   = 0;
    int abort_cnt = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: edges are numbered; a transaction is described by its grant and completion edges.
    int cyc, m_owner, m_last, m_grant, m_done_edge, m_idle_from, e_now, m_pick;
    logic m_to, m_nack;
    logic [15:0] m_rdata, m_ptr, m_wdata;
    logic [7:0]  m_slave;
    logic [1:0]  m_op;

    function automatic int rr_pick(input int last, input logic [2:0] req);
        int w = -1;
        for (int off = 1; off <= 3; off++) begin
            int idx = (last + off) % 3;
            if (w < 0 && req[idx]) w = idx;
        end
        return w;
    endfunction

    assign e_now  = cyc + 1;
    assign m_pick = rr_pick(m_last, REQ);

    always @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cyc <= 0; m_owner <= -1; m_last <= 2; m_grant <= 0; m_done_edge <= -1;
            m_idle_from <= 0; m_to <= 1'b0; m_nack <= 1'b0; m_rdata <= 16'h0;
            m_op <= 2'b00; m_slave <= 8'h0; m_ptr <= 16'h0; m_wdata <= 16'h0;
        end else begin
            cyc <= e_now;
            if (m_owner < 0) begin
                if (e_now - 1 >= m_idle_from && REQ != 3'b000) begin
                    m_owner     <= m_pick;
                    m_grant     <= e_now;
                    m_done_edge <= -1;
                    m_op        <= (REQ_OP[2*m_pick +: 2] == 2'b11) ? 2'b00 : REQ_OP[2*m_pick +: 2];
                    m_slave     <= REQ_SLAVE[8*m_pick +: 8];
                    m_ptr       <= REQ_PTR[16*m_pick +: 16];
                    m_wdata     <= REQ_WDATA[16*m_pick +: 16];
                end
            end else if (m_done_edge >= 0) begin
                if (e_now == m_done_edge + 1) begin
                    m_last      <= m_owner;
                    m_owner     <= -1;
                    m_idle_from <= e_now + ((GAP == 0) ? 1 : GAP);
                end
            end else if (e_now >= m_grant + 2) begin
                if (ENG_DONE) begin
                    m_done_edge <= e_now; m_to <= 1'b0; m_nack <= ENG_NACK; m_rdata <= ENG_RDATA;
                end else if (e_now == m_grant + 1 + TMO) begin
                    m_done_edge <= e_now; m_to <= 1'b1; m_nack <= 1'b0; m_rdata <= 16'h0;
                end
            end
        end
    end

    logic       done_now, exp_start, exp_abort, exp_busy;
    logic [2:0] exp_gnt, exp_done;
    logic [1:0] exp_err;
    always_comb begin
        done_now  = (m_owner >= 0) && (cyc == m_done_edge);
        exp_gnt   = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        exp_done  = done_now ? exp_gnt : 3'b000;
        exp_start = (m_owner >= 0) && (cyc == m_grant + 1);
        exp_abort = done_now && m_to;
        exp_busy  = (m_owner >= 0) || (cyc < m_idle_from);
        exp_err   = m_to ? 2'b10 : (m_nack ? 2'b01 : 2'b00);
    end

    always @(negedge CLK_50) begin
        if (chk_en) begin
            chk("GNT", GNT, exp_gnt);
            chk("DONE", DONE, exp_done);
            chk("BUSY", BUSY, exp_busy);
            chk("ENG_START", ENG_START, exp_start);
            chk("ENG_ABORT", ENG_ABORT, exp_abort);
            chk("ENG_OP", ENG_OP, m_op);
            chk("ENG_SLAVE", ENG_SLAVE, m_slave);
            chk("ENG_PTR", ENG_PTR, m_ptr);
            chk("ENG_WDATA", ENG_WDATA, m_wdata);
            if (done_now) begin
                chk("RDATA", RDATA, m_rdata);
                chk("ERR_CODE", ERR_CODE, exp_err);
            end
        end
    end

    always @(negedge CLK_50) if (ENG_ABORT) abort_cnt <= abort_cnt + 1;

    task automatic wait_gnt(output logic [2:0] gv, output int gc);
        bit seen = 1'b0;
        gv = 3'b000; gc = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK_50);
            if (GNT != 3'b000) begin seen = 1'b1; gv = GNT; gc = cyc; end
        end
        chk("gnt_seen", seen, 1);
    endtask

    // Acts as the engine: answer dly cycles after ENG_START is seen.
    task automatic run_eng(input int dly, input logic nack, input logic [15:0] rd,
                           output int s_c, output int d_c);
        bit seen = 1'b0;
        s_c = -1; d_c = -1;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (ENG_START) seen = 1'b1;
            else @(negedge CLK_50);
        end
        chk("start_seen", seen, 1);
        if (seen) begin
            s_c = cyc;
            repeat (dly) @(negedge CLK_50);
            ENG_DONE = 1'b1; ENG_NACK = nack; ENG_RDATA = rd;
            @(negedge CLK_50);
            ENG_DONE = 1'b0; ENG_NACK = 1'b0; ENG_RDATA = 16'h0;
            d_c = cyc;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_c, s_c, d_c, a_c, s2_c;
        logic [2:0] g_v;
        logic [2:0] rr_exp [4];
        logic [2:0] rr_gv [4];
        int rr_gc [4];
        int rr_dc [4];
        bit seen;
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        repeat (3) @(negedge CLK_50);
        chk("rst_gnt", GNT, 3'b000);
        chk("rst_busy", BUSY, 1'b0);
        RESET_N = 1'b1;
        chk_en  = 1'b1;
        @(negedge CLK_50);

        // Single read on requester 0.
        REQ_OP = 6'b000010; REQ_SLAVE = 24'h00001C; REQ_PTR = 48'h0; REQ_WDATA = 48'h0;
        REQ = 3'b001;
        wait_gnt(g_v, g_c);
        chk("t1_gnt", g_v, 3'b001);
        chk("t1_eng_op", ENG_OP, 2'b10);
        chk("t1_eng_slave", ENG_SLAVE, 8'h1C);
        run_eng(50, 1'b0, 16'h4401, s_c, d_c);
        chk("t1_start_after_gnt", s_c - g_c, 1);
        chk("t1_done", DONE, 3'b001);
        chk("t1_rdata", RDATA, 16'h4401);
        chk("t1_err", ERR_CODE, 2'b00);
        REQ = 3'b000;
        @(negedge CLK_50);
        chk("t1_done_one_cycle", DONE, 3'b000);
        ENG_DONE = 1'b1; ENG_RDATA = 16'hDEAD;
        @(negedge CLK_50);
        ENG_DONE = 1'b0; ENG_RDATA = 16'h0;

        // NACK on requester 1, with a stray completion during the launch cycle.
        REQ_OP = 6'b000000; REQ_SLAVE = 24'h003600; REQ = 3'b010;
        wait_gnt(g_v, g_c);
        chk("t2_gnt", g_v, 3'b010);
        ENG_DONE = 1'b1;
        @(negedge CLK_50);
        ENG_DONE = 1'b0;
        run_eng(5, 1'b1, 16'h1234, s_c, d_c);
        chk("t2_done", DONE, 3'b010);
        chk("t2_err_nack", ERR_CODE, 2'b01);
        chk("t2_no_abort", ENG_ABORT, 1'b0);
        REQ = 3'b000;

        // Completion in the same cycle as the watchdog expiry.
        REQ_OP = 6'b000001; REQ = 3'b001;
        wait_gnt(g_v, g_c);
        chk("t3_gnt", g_v, 3'b001);
        run_eng(TMO - 1, 1'b0, 16'hBEEF, s_c, d_c);
        chk("t3_done_edge", d_c - s_c, 100);
        chk("t3_done", DONE, 3'b001);
        chk("t3_err", ERR_CODE, 2'b00);
        chk("t3_rdata", RDATA, 16'hBEEF);
        chk("t3_no_abort", ENG_ABORT, 1'b0);
        REQ = 3'b000;

        // Timeout on requester 2 with the reserved op code.
        REQ_OP = 6'b110000; REQ_SLAVE = 24'h0C0000; REQ_PTR = 48'h1234_0000_0000;
        REQ_WDATA = 48'h5678_0000_0000; REQ = 3'b100;
        wait_gnt(g_v, g_c);
        chk("t4_gnt", g_v, 3'b100);
        chk("t4_op_reserved", ENG_OP, 2'b00);
        chk("t4_ptr", ENG_PTR, 16'h1234);
        chk("t4_wdata", ENG_WDATA, 16'h5678);
        @(negedge CLK_50);
        chk("t4_start", ENG_START, 1'b1);
        s2_c = cyc;
        seen = 1'b0; a_c = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK_50);
            if (ENG_ABORT) begin seen = 1'b1; a_c = cyc; end
        end
        chk("t4_abort_seen", seen, 1);
        chk("t4_abort_delay", a_c - s2_c, 100);
        chk("t4_done", DONE, 3'b100);
        chk("t4_err", ERR_CODE, 2'b10);
        chk("t4_rdata", RDATA, 16'h0000);
        REQ = 3'b000;

        // All three requesting continuously.
        REQ_OP = 6'b000110; REQ_SLAVE = 24'h0C361C;
        REQ_PTR = 48'h3333_2222_1111; REQ_WDATA = 48'hCCCC_BBBB_AAAA;
        REQ = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(rr_gv[i], rr_gc[i]);
            run_eng(3, 1'b0, 16'(i), s_c, rr_dc[i]);
            chk("rr_order", rr_gv[i], rr_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            chk("rr_spacing", rr_gc[i+1] - rr_dc[i], GAP + 2);
        end

        // Reset while requester 1 waits on the engine.
        wait_gnt(g_v, g_c);
        chk("t6_gnt", g_v, 3'b010);
        repeat (10) @(negedge CLK_50);
        chk("t6_gnt_wait", GNT, 3'b010);
        #3 RESET_N = 1'b0;
        #1;
        chk("t6_rst_gnt", GNT, 3'b000);
        chk("t6_rst_done", DONE, 3'b000);
        chk("t6_rst_busy", BUSY, 1'b0);
        chk("t6_rst_start", ENG_START, 1'b0);
        chk("t6_rst_abort", ENG_ABORT, 1'b0);
        chk("t6_rst_op", ENG_OP, 2'b00);
        chk("t6_rst_slave", ENG_SLAVE, 8'h00);
        chk("t6_rst_ptr", ENG_PTR, 16'h0000);
        chk("t6_rst_wdata", ENG_WDATA, 16'h0000);
        chk("t6_rst_rdata", RDATA, 16'h0000);
        chk("t6_rst_err", ERR_CODE, 2'b00);
        repeat (2) @(negedge CLK_50);
        RESET_N = 1'b1;
        wait_gnt(g_v, g_c);
        chk("t6_first_gnt", g_v, 3'b001);
        run_eng(2, 1'b0, 16'h0F0F, s_c, d_c);
        REQ = 3'b000;
        repeat (10) @(negedge CLK_50);
        chk("abort_total", abort_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
